idiv_iter: RTL and testbench
============================

Name: idiv_iter

Overview:
- Iterative integer divider execution unit; the inverse-operation companion to the multiply unit in the integer ALU cluster.
- Accepts one 32- or 64-bit signed/unsigned divide per start pulse.
- Produces quotient or remainder plus the 6-bit flag vector in the same format as the multiplier.
- Multi-cycle and non-pipelined. Signals busy to the scheduler until its result is written back.

Parameters:
BITS_PER_CYC, 1, quotient bits retired per iteration cycle; legal values 1, 2, 4.
WIDTH, 64, datapath width; the operand tag bit sits above it at bit WIDTH.

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-low
clkEn  in  1  pipeline enable; when low, all state and outputs hold
en  in  1  start request
op  in  3  [0] signed, [1] select remainder (0 = quotient), [2] short 32-bit operation
R  in  65  dividend; bit 64 is the pointer tag and is ignored
C  in  65  divisor; bit 64 is ignored
kill  in  1  flush; abandons the current operation
busy  out  1  unit occupied
Res  out  65  result; bit 64 is always 0
Res_valid  out  1  one-cycle result strobe
flg  out  6  {CF,OF,0,SF,ZF,PF}
dz  out  1  divide-by-zero, qualified by Res_valid

Behaviour:
- Reset (rst low, asynchronous): state machine goes to IDLE. busy, Res_valid, dz, Res and flg are all 0.
- State machine: IDLE -> PREP -> ITER -> FIX -> DONE -> IDLE. All transitions require clkEn=1.
- Accept: en=1 and busy=0 at a clk edge. Operands and op are latched. Next state is PREP.
  - en while busy=1 is ignored; there is no queue.
- PREP (1 cycle):
  - Short op: take the low 32 bits of each operand; sign-extend if signed.
  - Signed op: take absolute values; record quotient sign = sign(R) xor sign(C) and remainder sign = sign(R).
  - Detect divide-by-zero (divisor==0) and signed overflow (R = most-negative value, C = -1).
  - If either is detected, go straight to FIX.
- ITER: restoring shift-subtract, BITS_PER_CYC quotient bits per cycle.
  - Iteration count is 64/BITS_PER_CYC (long) or 32/BITS_PER_CYC (short).
  - The counter counts down; the last iteration is at count 1, then go to FIX.
- FIX (1 cycle): apply recorded signs; select quotient or remainder; compute flags.
- DONE:
  - Res_valid=1 for exactly one cycle; Res and flg are valid in that cycle.
  - busy is low in the DONE cycle, so an en in that cycle is accepted (back-to-back).
  - Res and flg hold their values until the next DONE.
- busy=1 from the edge after accept through FIX inclusive.
- Latency (accept edge to Res_valid cycle), with clkEn held high:
  - Normal case: 2 + iterations + 1. Long, BITS_PER_CYC=1: 67 cycles. Short, BITS_PER_CYC=1: 35 cycles.
  - Divide-by-zero or overflow: 3 cycles.
- clkEn=0 cycles freeze the machine and add one cycle of latency each. Res_valid stays held if clkEn drops during DONE.
- Divide-by-zero result:
  - Quotient = all ones for the operation width; remainder = dividend.
  - dz=1; CF=OF=1.
- Signed-overflow result: quotient = most-negative value; remainder = 0; OF=CF=1; dz=0.
- Result width:
  - Short: result is in Res[31:0]; Res[63:32]=0.
  - Long: result is in Res[63:0].
  - Res[64]=0 always.
- Flags:
  - SF = result MSB of the operation width (bit 31 or bit 63).
  - ZF = result of the operation width is zero.
  - PF = even parity of Res[7:0].
  - CF = OF = 0 except on overflow or divide-by-zero.
  - Bit 3 = 0.
- kill:
  - Any state except IDLE goes to IDLE at the next edge; no Res_valid is produced.
  - kill and en in the same cycle: kill wins and en is dropped.
  - kill in the DONE cycle does not suppress the strobe already asserted in that cycle.
- Asynchronous reset mid-operation: immediate IDLE; no stale Res_valid after rst deasserts.

Test Plan:
- Unsigned long 100 / 7, op=000 -> Res_valid at cycle 67, Res=14, flg=6'b000000. Repeat with op=010 -> Res=2, ZF=0, PF=0.
- Signed short -7 / 2, op=101 -> Res=32'hFFFFFFFD, Res[63:32]=0, SF=1, at cycle 35. Remainder op=111 -> Res=32'hFFFFFFFF, PF=1.
- Divide-by-zero, long unsigned, R=5, C=0 -> Res_valid at cycle 3, Res=64'hFFFF_FFFF_FFFF_FFFF, dz=1, CF=OF=1. Remainder op -> Res=5.
- Signed long 64'h8000_0000_0000_0000 / -1 -> Res=64'h8000_0000_0000_0000, OF=1, dz=0, cycle 3.
- kill at iteration 10 -> no Res_valid and busy=0 next cycle. Back-to-back: en in the DONE cycle is accepted, and the second result arrives 67 cycles later.
- clkEn low for 5 cycles mid-ITER -> latency 72. rst pulsed low mid-ITER -> busy=0 and Res_valid=0 immediately, and no strobe afterward.

Source files
------------

// File: rtl/idiv_iter.sv
// idiv_iter: iterative restoring integer divider, 32/64-bit signed/unsigned, quotient or remainder with ALU flags.
module idiv_iter #(
  parameter int BITS_PER_CYC = 1,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clkEn,
  input  logic             en,
  input  logic [2:0]       op,
  input  logic [WIDTH:0]   R,
  input  logic [WIDTH:0]   C,
  input  logic             kill,
  output logic             busy,
  output logic [WIDTH:0]   Res,
  output logic             Res_valid,
  output logic [5:0]       flg,
  output logic             dz
);
  localparam int H = WIDTH / 2;
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] MN_L = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MN_S = {{(H+1){1'b1}}, {(H-1){1'b0}}};
  localparam logic [WIDTH-1:0] LO = {{H{1'b0}}, {H{1'b1}}};

  typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] r_q, r_d, c_q, c_d, quo_q, quo_d, dvs_q, dvs_d, res_q, res_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             qneg_q, qneg_d, rneg_q, rneg_d, zero_q, zero_d, ovf_q, ovf_d, dz_q, dz_d;
  logic [5:0]       flg_q, flg_d;
  logic             sh, sg, a_sn, b_sn, sf;
  logic [WIDTH-1:0] a, b, a_abs, b_abs, qt, qv, rv, mask, res;
  logic [WIDTH:0]   rm, diff;
  logic             unused_tags;

  assign unused_tags = R[WIDTH] ^ C[WIDTH];
  assign sh = op_q[2];
  assign sg = op_q[0];
  assign busy = state_q inside {PREP, ITER, FIX};
  assign Res_valid = state_q == DONE;
  assign Res = {1'b0, res_q};
  assign flg = flg_q;
  assign dz = dz_q;

  always_comb begin
    a = sh ? {{H{sg & r_q[H-1]}}, r_q[H-1:0]} : r_q;
    b = sh ? {{H{sg & c_q[H-1]}}, c_q[H-1:0]} : c_q;
    a_sn = sg & a[WIDTH-1];
    b_sn = sg & b[WIDTH-1];
    a_abs = a_sn ? -a : a;
    b_abs = b_sn ? -b : b;
    rm = rem_q;
    qt = quo_q;
    diff = {(WIDTH+1){1'b0}};
    // The partial remainder keeps one extra bit so an unsigned 64-bit divisor never overflows the compare.
    for (int i = 0; i < BITS_PER_CYC; i++) begin
      rm = {rm[WIDTH-1:0], qt[WIDTH-1]};
      diff = rm - {1'b0, dvs_q};
      qt = {qt[WIDTH-2:0], ~diff[WIDTH]};
      rm = diff[WIDTH] ? rm : diff;
    end
    mask = sh ? LO : {WIDTH{1'b1}};
    qv = qneg_q ? -quo_q : quo_q;
    rv = rneg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
    res = mask & (zero_q ? (op_q[1] ? a : {WIDTH{1'b1}}) :
                  ovf_q  ? (op_q[1] ? {WIDTH{1'b0}} : (sh ? MN_S : MN_L)) :
                  op_q[1] ? rv : qv);
    sf = sh ? res[H-1] : res[WIDTH-1];
  end

  always_comb begin
    state_d = state_q;
    op_d = op_q;
    r_d = r_q;
    c_d = c_q;
    quo_d = quo_q;
    rem_d = rem_q;
    dvs_d = dvs_q;
    cnt_d = cnt_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    zero_d = zero_q;
    ovf_d = ovf_q;
    res_d = res_q;
    flg_d = flg_q;
    dz_d = dz_q;
    if (kill) state_d = IDLE;
    else if (en && !busy) begin
      state_d = PREP;
      op_d = op;
      r_d = R[WIDTH-1:0];
      c_d = C[WIDTH-1:0];
    end else if (state_q == PREP) begin
      zero_d = b == '0;
      ovf_d = sg && a == (sh ? MN_S : MN_L) && b == {WIDTH{1'b1}};
      quo_d = sh ? a_abs << H : a_abs;
      rem_d = '0;
      dvs_d = b_abs;
      cnt_d = sh ? CW'(H / BITS_PER_CYC) : CW'(WIDTH / BITS_PER_CYC);
      qneg_d = a_sn ^ b_sn;
      rneg_d = a_sn;
      state_d = (zero_d || ovf_d) ? FIX : ITER;
    end else if (state_q == ITER) begin
      quo_d = qt;
      rem_d = rm;
      cnt_d = cnt_q - 1'b1;
      state_d = cnt_q == CW'(1) ? FIX : ITER;
    end else if (state_q == FIX) begin
      res_d = res;
      flg_d = {zero_q | ovf_q, zero_q | ovf_q, 1'b0, sf, res == '0, ~^res[7:0]};
      dz_d = zero_q;
      state_d = DONE;
    end else if (state_q == DONE) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      op_q <= '0;
      r_q <= '0;
      c_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      zero_q <= 1'b0;
      ovf_q <= 1'b0;
      res_q <= '0;
      flg_q <= '0;
      dz_q <= 1'b0;
    end else if (clkEn) begin
      state_q <= state_d;
      op_q <= op_d;
      r_q <= r_d;
      c_q <= c_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
      zero_q <= zero_d;
      ovf_q <= ovf_d;
      res_q <= res_d;
      flg_q <= flg_d;
      dz_q <= dz_d;
    end
  end
endmodule

// File: tb/tb_idiv_iter.sv
// tb_idiv_iter: randomized and directed checks of idiv_iter against a plain-arithmetic divide model.
module tb_idiv_iter;
  localparam int BPC = 1;

  logic        clk = 1'b0, rst = 1'b0, clkEn = 1'b1, en = 1'b0, kill = 1'b0;
  logic [2:0]  op = '0;
  logic [64:0] R = '0, C = '0;
  logic        busy, Res_valid, dz;
  logic [64:0] Res;
  logic [5:0]  flg;
  int          nvec = 0, nerr = 0;

  typedef struct {
    logic [2:0]  o;
    logic [64:0] r;
    logic [64:0] c;
    logic [79:0] e;
    string       nm;
  } vec_t;

  idiv_iter #(.BITS_PER_CYC(BPC), .WIDTH(64)) dut (
    .clk(clk), .rst(rst), .clkEn(clkEn), .en(en), .op(op), .R(R), .C(C), .kill(kill),
    .busy(busy), .Res(Res), .Res_valid(Res_valid), .flg(flg), .dz(dz)
  );

  always #5 clk = ~clk;

  // Expected {Res, flg, dz, latency} straight from integer arithmetic.
  function automatic logic [79:0] model(input logic [2:0] o, input logic [64:0] r, input logic [64:0] c);
    logic [31:0] a32, b32, q32, m32;
    logic [63:0] a64, b64, q64, m64, res;
    logic        z, v;
    int          lat;
    a32 = r[31:0];
    b32 = c[31:0];
    a64 = r[63:0];
    b64 = c[63:0];
    if (o[2]) begin
      z = b32 == '0;
      v = o[0] && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF;
      if (z) begin q32 = '1; m32 = a32; end
      else if (v) begin q32 = 32'h8000_0000; m32 = '0; end
      else if (o[0]) begin q32 = 32'($signed(a32) / $signed(b32)); m32 = 32'($signed(a32) % $signed(b32)); end
      else begin q32 = a32 / b32; m32 = a32 % b32; end
      res = {32'h0, o[1] ? m32 : q32};
    end else begin
      z = b64 == '0;
      v = o[0] && a64 == 64'h8000_0000_0000_0000 && b64 == 64'hFFFF_FFFF_FFFF_FFFF;
      if (z) begin q64 = '1; m64 = a64; end
      else if (v) begin q64 = 64'h8000_0000_0000_0000; m64 = '0; end
      else if (o[0]) begin q64 = 64'($signed(a64) / $signed(b64)); m64 = 64'($signed(a64) % $signed(b64)); end
      else begin q64 = a64 / b64; m64 = a64 % b64; end
      res = o[1] ? m64 : q64;
    end
    lat = (z || v) ? 3 : (o[2] ? 32 : 64) / BPC + 3;
    return {1'b0, res, z || v, z || v, 1'b0, o[2] ? res[31] : res[63], res == '0, ~^res[7:0], z, 8'(lat)};
  endfunction

  // Issues one divide and waits for its strobe; latency counts the accept edge as 1.
  task automatic do_div(input logic [2:0] o, input logic [64:0] r, input logic [64:0] c, input bit now,
                        output logic [79:0] obs);
    int n;
    if (!now) @(negedge clk);
    op = o; R = r; C = c; en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    n = 1;
    while (!Res_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    obs = {Res, flg, dz, Res_valid ? 8'(n) : 8'hFF};
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    nvec++;
    if ({busy, Res_valid, dz, Res, flg} !== '0) begin
      nerr++;
      $display("FAIL reset: busy=%b Res_valid=%b dz=%b Res=%h flg=%b, expected all zero", busy, Res_valid, dz, Res, flg);
    end
    rst = 1'b1;
  endtask

  task automatic test_plan;
    vec_t tv[$];
    logic [79:0] obs;
    tv.push_back('{3'b000, 65'd100, 65'd7, {65'd14, 6'b000000, 1'b0, 8'd67}, "u64_quot"});
    tv.push_back('{3'b010, 65'd100, 65'd7, {65'd2, 6'b000000, 1'b0, 8'd67}, "u64_rem"});
    tv.push_back('{3'b101, 65'h1_FFFF_FFFF_FFFF_FFF9, 65'd2, {65'h0_0000_0000_FFFF_FFFD, 6'b000100, 1'b0, 8'd35}, "s32_quot"});
    tv.push_back('{3'b111, 65'h1_FFFF_FFFF_FFFF_FFF9, 65'd2, {65'h0_0000_0000_FFFF_FFFF, 6'b000101, 1'b0, 8'd35}, "s32_rem"});
    tv.push_back('{3'b000, 65'd5, 65'd0, {65'h0_FFFF_FFFF_FFFF_FFFF, 6'b110101, 1'b1, 8'd3}, "dz_quot"});
    tv.push_back('{3'b010, 65'd5, 65'h1_0000_0000_0000_0000, {65'd5, 6'b110001, 1'b1, 8'd3}, "dz_rem"});
    tv.push_back('{3'b001, 65'h0_8000_0000_0000_0000, 65'h1_FFFF_FFFF_FFFF_FFFF, {65'h0_8000_0000_0000_0000, 6'b110101, 1'b0, 8'd3}, "ovf_quot"});
    tv.push_back('{3'b011, 65'h0_8000_0000_0000_0000, 65'h1_FFFF_FFFF_FFFF_FFFF, {65'd0, 6'b110011, 1'b0, 8'd3}, "ovf_rem"});
    foreach (tv[i]) begin
      do_div(tv[i].o, tv[i].r, tv[i].c, 1'b0, obs);
      nvec++;
      if (obs !== tv[i].e) begin
        nerr++;
        $display("FAIL plan_%s: got {Res,flg,dz,lat}=%h expected %h", tv[i].nm, obs, tv[i].e);
      end
    end
  endtask

  task automatic test_random;
    logic [2:0]  o;
    logic [64:0] r, c;
    logic [79:0] obs, exp;
    int          sel;
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 7));
      r = {1'($urandom), $urandom, $urandom};
      c = {1'($urandom), $urandom, $urandom};
      sel = $urandom_range(0, 5);
      if (sel == 0) c[63:0] = '0;
      else if (sel == 1) begin
        c[63:0] = '1;
        if ($urandom_range(0, 1) == 1) begin
          if (o[2]) r[31:0] = 32'h8000_0000;
          else r[63:0] = 64'h8000_0000_0000_0000;
        end
      end else if (sel == 2) begin
        c[63:0] = 64'($urandom_range(1, 20));
        if ($urandom_range(0, 1) == 1) c[63:0] = -c[63:0];
      end else if (sel == 3) c[63:32] = '0;
      exp = model(o, r, c);
      do_div(o, r, c, 1'b0, obs);
      nvec++;
      if (obs !== exp) begin
        nerr++;
        $display("FAIL random op=%b R=%h C=%h: got {Res,flg,dz,lat}=%h expected %h", o, r, c, obs, exp);
      end
      @(negedge clk);
      nvec++;
      if (Res_valid !== 1'b0) begin
        nerr++;
        $display("FAIL strobe_width: Res_valid=%b one cycle after strobe, expected 0", Res_valid);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [64:0] r1, r2;
    logic [79:0] obs, exp;
    r1 = {1'b0, $urandom, $urandom};
    r2 = {1'b1, $urandom, $urandom};
    exp = model(3'b000, r1, 65'd13);
    do_div(3'b000, r1, 65'd13, 1'b0, obs);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL b2b_first: got %h expected %h", obs, exp);
    end
    exp = model(3'b001, r2, 65'd3);
    do_div(3'b001, r2, 65'd3, 1'b1, obs);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL b2b_second: got %h expected %h", obs, exp);
    end
    op = 3'b000; R = 65'd9; C = 65'd3; en = 1'b1; kill = 1'b1;
    @(negedge clk);
    en = 1'b0; kill = 1'b0;
    nvec++;
    if ({busy, Res_valid} !== 2'b00) begin
      nerr++;
      $display("FAIL kill_beats_en_done: busy=%b Res_valid=%b expected 0 0", busy, Res_valid);
    end
  endtask

  task automatic test_busy_ignore;
    logic [64:0] r;
    logic [79:0] obs, exp;
    int          n;
    r = {1'b0, $urandom, $urandom};
    exp = model(3'b010, r, 65'd1000);
    @(negedge clk);
    op = 3'b010; R = r; C = 65'd1000; en = 1'b1;
    @(negedge clk);
    n = 1;
    while (!Res_valid && n < 300) begin
      en = n == 5;
      if (n == 5) begin
        op = 3'b101; R = 65'd77; C = 65'd0;
        nvec++;
        if (busy !== 1'b1) begin
          nerr++;
          $display("FAIL busy_mid_op: busy=%b expected 1", busy);
        end
      end
      @(negedge clk);
      n++;
    end
    en = 1'b0;
    obs = {Res, flg, dz, Res_valid ? 8'(n) : 8'hFF};
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL en_while_busy: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_kill;
    int s;
    @(negedge clk);
    op = 3'b000; R = {1'b0, $urandom, $urandom}; C = 65'd7; en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    repeat (10) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    nvec++;
    if ({busy, Res_valid} !== 2'b00) begin
      nerr++;
      $display("FAIL kill_iter: busy=%b Res_valid=%b expected 0 0", busy, Res_valid);
    end
    s = 0;
    repeat (80) begin
      @(negedge clk);
      if (Res_valid) s++;
    end
    nvec++;
    if (s != 0) begin
      nerr++;
      $display("FAIL kill_no_strobe: %0d strobes after kill, expected 0", s);
    end
    op = 3'b000; R = 65'd50; C = 65'd5; en = 1'b1; kill = 1'b1;
    @(negedge clk);
    en = 1'b0; kill = 1'b0;
    nvec++;
    if (busy !== 1'b0) begin
      nerr++;
      $display("FAIL kill_beats_en_idle: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_clken;
    logic [64:0] r;
    logic [79:0] obs, exp;
    logic        hold;
    int          n;
    r = {1'b1, $urandom, $urandom};
    exp = model(3'b000, r, 65'd11);
    exp[7:0] = exp[7:0] + 8'd5;
    @(negedge clk);
    op = 3'b000; R = r; C = 65'd11; en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    n = 1;
    while (!Res_valid && n < 300) begin
      clkEn = n < 20 || n >= 25;
      @(negedge clk);
      n++;
    end
    clkEn = 1'b1;
    obs = {Res, flg, dz, Res_valid ? 8'(n) : 8'hFF};
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL clken_stall: got %h expected %h", obs, exp);
    end
    clkEn = 1'b0;
    hold = 1'b1;
    repeat (3) begin
      @(negedge clk);
      hold = hold & Res_valid;
    end
    nvec++;
    if (hold !== 1'b1) begin
      nerr++;
      $display("FAIL clken_hold_done: Res_valid dropped while clkEn low, got %b expected 1", hold);
    end
    clkEn = 1'b1;
    @(negedge clk);
    nvec++;
    if (Res_valid !== 1'b0) begin
      nerr++;
      $display("FAIL clken_release: Res_valid=%b expected 0", Res_valid);
    end
  endtask

  task automatic test_async_reset;
    int s;
    @(negedge clk);
    op = 3'b000; R = {1'b0, $urandom, $urandom}; C = 65'd5; en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    nvec++;
    if ({busy, Res_valid} !== 2'b00) begin
      nerr++;
      $display("FAIL async_reset: busy=%b Res_valid=%b expected 0 0 before any edge", busy, Res_valid);
    end
    @(negedge clk);
    rst = 1'b1;
    s = 0;
    repeat (80) begin
      @(negedge clk);
      if (Res_valid || busy) s++;
    end
    nvec++;
    if (s != 0) begin
      nerr++;
      $display("FAIL async_reset_stale: %0d cycles with busy/Res_valid after reset, expected 0", s);
    end
  endtask

  initial begin
    test_reset;
    test_plan;
    test_random;
    test_back_to_back;
    test_busy_ignore;
    test_kill;
    test_clken;
    test_async_reset;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
